// File: rtl/ps2_rx_controller.sv
// PS/2 device receiver: pin synchronisation, ps2_clk glitch filter, 11-bit frame
// sequencer with inter-edge watchdog, and a valid/ack holding register for the byte.
module ps2_rx_controller #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       enable,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Odd parity holds when byte and parity bit together carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] byte_v, input logic par_v);
        return ^{byte_v, par_v};
    endfunction

    logic          clk_sync_p0, clk_sync_p1;
    logic          data_sync_p0, data_sync_p1;
    logic [FW-1:0] filt_cnt;
    logic          clk_filt, clk_filt_prev;
    logic          fall;

    logic [1:0]    state, state_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift_reg, shift_nx;
    logic          parity_bit, parity_nx;
    logic [WW-1:0] wdog, wdog_nx;
    logic          frame_good, frame_perr, frame_ferr;

    // Stage p0/p1: two-flop synchronisers, reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            clk_sync_p0  <= ps2_clk;
            clk_sync_p1  <= clk_sync_p0;
            data_sync_p0 <= ps2_data;
            data_sync_p1 <= data_sync_p0;
        end
    end

    // Filter stage: filtered clock moves only after FILTER_LEN disagreeing samples in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt      <= '0;
            clk_filt      <= 1'b1;
            clk_filt_prev <= 1'b1;
        end else begin
            clk_filt_prev <= clk_filt;
            if (clk_sync_p1 != clk_filt) begin
                if (filt_cnt == FILT_LAST) begin
                    clk_filt <= clk_sync_p1;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = clk_filt_prev & ~clk_filt;

    // Frame stage: next-state logic for the sequencer and watchdog.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift_reg;
        parity_nx  = parity_bit;
        wdog_nx    = wdog;
        frame_good = 1'b0;
        frame_perr = 1'b0;
        frame_ferr = 1'b0;

        if (!enable) begin
            state_nx   = ST_IDLE;
            bit_cnt_nx = '0;
            wdog_nx    = '0;
        end else if (fall) begin
            wdog_nx = '0;
            case (state)
                ST_IDLE: begin
                    if (!data_sync_p1) begin
                        state_nx   = ST_DATA;
                        bit_cnt_nx = '0;
                    end
                end
                ST_DATA: begin
                    shift_nx   = {data_sync_p1, shift_reg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nx = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_nx = data_sync_p1;
                    state_nx  = ST_STOP;
                end
                default: begin
                    state_nx = ST_IDLE;
                    if (!data_sync_p1) begin
                        frame_ferr = 1'b1;
                    end else if (!odd_parity_ok(shift_reg, parity_bit)) begin
                        frame_perr = 1'b1;
                    end else begin
                        frame_good = 1'b1;
                    end
                end
            endcase
        end else if (state == ST_IDLE) begin
            wdog_nx = '0;
        end else if (wdog == WD_LAST) begin
            // Device stalled mid-frame: drop the partial byte and resynchronise.
            state_nx   = ST_IDLE;
            bit_cnt_nx = '0;
            shift_nx   = '0;
            wdog_nx    = '0;
            frame_ferr = 1'b1;
        end else begin
            wdog_nx = wdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            wdog       <= '0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            shift_reg  <= shift_nx;
            parity_bit <= parity_nx;
            wdog       <= wdog_nx;
        end
    end

    assign busy = (state != ST_IDLE);

    // Output stage: holding register, handshake and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= frame_perr;
            frame_err  <= frame_ferr;
            overrun    <= 1'b0;
            if (frame_good) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid & ~rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ps2_rx_controller.md
Name: ps2_rx_controller

Overview:
- Receives PS/2 keyboard/device frames for the game's player input path.
- Synchronises and glitch-filters ps2_clk, detects its falling edges, and sequences an 11-bit frame (start, 8 data LSB-first, odd parity, stop) through an FSM with a watchdog.
- Delivers validated bytes through a valid/ack holding register to the input-decoding logic.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2_clk samples required before the filtered clock changes (min 2)
TIMEOUT_CYCLES, 50000, max clk cycles between falling edges inside a frame (1 ms at 50 MHz)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idles high
ps2_data  input  1  raw PS/2 data pin, asynchronous, idles high
enable  input  1  receiver enable; low aborts and suppresses reception
rx_ack  input  1  consumer acknowledge; clears rx_valid
rx_data  output  8  last good byte
rx_valid  output  1  level; high while rx_data holds an unacknowledged byte
parity_err  output  1  1-cycle pulse: frame dropped, parity wrong
frame_err  output  1  1-cycle pulse: frame dropped, stop bit 0 or timeout
overrun  output  1  1-cycle pulse: good byte overwrote an unacknowledged byte
busy  output  1  high when FSM not in IDLE

Behaviour:
- One clock, one reset. Reset is synchronous and active-high.
- Reset state: rx_data=0, rx_valid=0, all pulses=0, busy=0, FSM=IDLE, bit counter=0, watchdog=0. Sync registers, filtered clock and previous-filtered register all reset to 1 (idle bus, no false edge after reset).
- Synchroniser: 2-FF chain on each pin.
- Glitch filter: counter of consecutive synchronised ps2_clk samples differing from the filtered value. Filtered value flips when the count reaches FILTER_LEN. Any agreeing sample clears the counter.
- fall = prev_filt & ~filt, a 1-cycle strobe. ps2_data is sampled (synchronised) in the fall cycle.
- FSM transitions, on fall with enable=1:
  - IDLE: data=0 -> DATA, bit counter=0; data=1 -> stay IDLE, no error.
  - DATA: shift reg <= {data, shift[7:1]}, counter++. After the 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: evaluate the frame, then -> IDLE.
- STOP evaluation:
  - stop=0 -> frame_err pulse.
  - else ^{byte,parity}=0 -> parity_err pulse.
  - else good frame: rx_data <= byte, rx_valid <= 1 on the next clk edge (fall-to-rx_valid latency 1 cycle).
  - Errors and pulses also appear 1 cycle after the STOP fall.
  - Errored frames never modify rx_data or rx_valid.
- Watchdog:
  - Cleared on every fall and while IDLE; increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 in DATA, PARITY or STOP -> FSM to IDLE, frame_err pulse, shift reg discarded.
- enable=0:
  - FSM forced to IDLE next cycle; falls ignored; no error pulse.
  - Synchroniser and filter keep running.
  - rx_valid and rx_ack handling unaffected.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next cycle.
  - rx_ack with rx_valid=0 has no effect.
- Simultaneous good-frame completion and rx_ack: new byte loaded, rx_valid stays 1, no overrun.
- Good frame while rx_valid=1 and no ack: rx_data overwritten, rx_valid stays 1, overrun pulse.
- busy = (FSM != IDLE), registered with the FSM.
- rst mid-frame: everything returns to reset values next cycle, and a pending rx_valid is lost.

Test Plan:
- FILTER_LEN=4, TIMEOUT_CYCLES=200; PS/2 bit period 40 clk; data changes mid-high phase.
  - Send 0x1C, parity 0, stop 1 -> rx_valid=1, rx_data=0x1C, no error pulses, busy low after the stop fall. rx_ack 1 cycle -> rx_valid=0.
  - Send 0x1C with parity 1 -> single parity_err pulse, rx_valid stays 0, rx_data unchanged.
  - Send 0xF0, parity 1, stop 0 -> single frame_err pulse, rx_valid 0.
- Timeout and recovery:
  - Start bit + 4 data bits, then ps2_clk held high -> frame_err pulse 200 cycles after the last fall, busy=0.
  - Then a full 0xF0 frame (parity 1) -> rx_data=0xF0, rx_valid=1.
- Overrun and glitch rejection:
  - 0x1C then 0x32 (parity 0) with no ack -> rx_data=0x32, rx_valid=1, one overrun pulse.
  - 2-cycle low glitch on ps2_clk in IDLE -> no fall, busy stays 0.
- Enable and reset:
  - enable dropped after 3 data bits -> busy=0 next cycle, no pulses.
  - enable restored and a 0x32 frame sent -> received correctly.
  - rst asserted mid-frame -> all outputs 0 next cycle.
